// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: UART state encodings and oversampling constants shared by TX, RX and the baud generator
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK = 7;
  // 50 MHz / (16 * 115200) - 1
  localparam int BAUD_COUNT = 26;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, reset to a chosen idle level
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, mid-bit sampling, LSB-first words with framing-error flag
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);
  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, dout_q, dout_d;
  logic            done_q, done_d, ferr_q, ferr_d;
  logic            rx_s, mid_start, bit_end, stop_end, last_bit;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clock), .rst(reset), .d_i(rx), .q_o(rx_s));
  assign mid_start = s_tick && s_q == S_MID;
  assign bit_end   = s_tick && s_q == S_BIT;
  assign stop_end  = s_tick && s_q == S_STOP;
  assign last_bit  = n_q == 3'(DBIT - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    case (state_q)
      IDLE:    state_d = rx_s ? IDLE : START;
      START:   state_d = mid_start ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_d = (bit_end && last_bit) ? STOP : DATA;
      default: state_d = stop_end ? IDLE : STOP;
    endcase
  end
  // A high mid-start sample is a glitch: leave every output untouched
  always_comb begin
    s_d    = s_tick ? s_q + 1'b1 : s_q;
    n_d    = n_q;
    b_d    = b_q;
    dout_d = dout_q;
    done_d = 1'b0;
    ferr_d = ferr_q;
    case (state_q)
      IDLE: s_d = '0;
      START: if (mid_start) begin
        s_d = '0;
        n_d = '0;
      end
      DATA: if (bit_end) begin
        s_d = '0;
        b_d = {rx_s, b_q[DBIT-1:1]};
        n_d = last_bit ? n_q : n_q + 3'd1;
      end
      default: if (stop_end) begin
        s_d    = '0;
        done_d = 1'b1;
        dout_d = b_q;
        ferr_d = ~rx_s;
      end
    endcase
  end
  always_comb begin
    busy         = state_q != IDLE;
    dout         = dout_q;
    rx_done_tick = done_q;
    frame_err    = ferr_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level scoreboard for uart_rx driven by a COUNT=3 tick generator (64 clocks per bit)
module tb_uart_rx;
  logic       clock = 1'b0, reset = 1'b1, rx = 1'b1, s_tick;
  logic [7:0] dout, dout2;
  logic       rx_done_tick, frame_err, busy, done2, ferr2, busy2;
  logic [1:0] tcnt = 2'd0;
  int         passed = 0, total = 0, cyc = 0, n2 = 0, t1 = 0, t2 = 0;
  logic [8:0] got_q[$], exp_q[$];
  int         time_q[$];
  logic [7:0] last_dout = 8'h00;

  always #5 clock = ~clock;
  always @(posedge clock) begin
    tcnt <= tcnt + 2'd1;
    cyc  <= cyc + 1;
  end
  assign s_tick = tcnt == 2'd3;

  uart_rx dut (.clock(clock), .reset(reset), .rx(rx), .s_tick(s_tick), .dout(dout),
               .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy));
  uart_rx #(.SB_TICK(32)) dut2 (.clock(clock), .reset(reset), .rx(rx), .s_tick(s_tick), .dout(dout2),
               .rx_done_tick(done2), .frame_err(ferr2), .busy(busy2));

  always @(negedge clock) begin
    if (rx_done_tick) begin
      got_q.push_back({frame_err, dout});
      time_q.push_back(cyc);
      t1 = cyc;
    end
    if (done2) begin
      n2++;
      t2 = cyc;
    end
  end

  task automatic drive(input logic v, input int clocks);
    rx = v;
    repeat (clocks) @(negedge clock);
  endtask

  // Reference: a word arrives LSB first; frame_err is the complement of the stop level
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int stop_bits);
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
    if (stop_ok) drive(1'b1, 64 * stop_bits);
    else begin
      drive(1'b0, 40);
      drive(1'b1, 24);
    end
    exp_q.push_back({~stop_ok, d});
    last_dout = d;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    total++;
    if ({dout, rx_done_tick, frame_err, busy} !== 11'd0) $display("FAIL reset_state got %h exp 0", {dout, rx_done_tick, frame_err, busy});
    else passed++;
    reset = 1'b0;
    drive(1'b1, 100);
  endtask

  task automatic test_single;
    send_frame(8'h55, 1'b1, 1);
    drive(1'b1, 64);
    total++;
    if (got_q.size() != exp_q.size()) $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL single_word got %h exp %h", (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else passed++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL single_busy got %b exp 0", busy);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_back_to_back;
    send_frame(8'hA3, 1'b1, 1);
    send_frame(8'h0F, 1'b1, 1);
    drive(1'b1, 128);
    total++;
    if (got_q.size() != 2) $display("FAIL b2b_count got %0d exp 2", got_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL b2b_word got %h exp %h", (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else passed++;
    end
    total++;
    if (time_q.size() != 2 || time_q[1] - time_q[0] != 640) $display("FAIL b2b_spacing got %0d exp 640", (time_q.size() == 2) ? time_q[1] - time_q[0] : -1);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_glitch;
    drive(1'b0, 16);
    drive(1'b1, 400);
    total++;
    if (got_q.size() != 0) $display("FAIL glitch_strobe got %0d exp 0", got_q.size());
    else passed++;
    total++;
    if (dout !== last_dout || busy !== 1'b0) $display("FAIL glitch_hold got %h/%b exp %h/0", dout, busy, last_dout);
    else passed++;
    got_q.delete(); time_q.delete();
  endtask

  task automatic test_frame_err;
    send_frame(8'hC3, 1'b0, 1);
    drive(1'b1, 64);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 9'h1C3) $display("FAIL ferr_bad got %h exp 1c3", (got_q.size() > 0) ? got_q[0] : 9'h0);
    else passed++;
    send_frame(8'h01, 1'b1, 1);
    drive(1'b1, 64);
    total++;
    if (got_q.size() != exp_q.size()) $display("FAIL ferr_count got %0d exp %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL ferr_word got %h exp %h", (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else passed++;
    end
    total++;
    if (frame_err !== 1'b0) $display("FAIL ferr_clear got %b exp 0", frame_err);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(1'b1, 64);
    drive(1'b1, 32);
    total++;
    if (busy !== 1'b1) $display("FAIL rst_mid_busy_before got %b exp 1", busy);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({dout, rx_done_tick, frame_err, busy} !== 11'd0) $display("FAIL rst_mid_outputs got %h exp 0", {dout, rx_done_tick, frame_err, busy});
    else passed++;
    last_dout = 8'h00;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 200);
    total++;
    if (got_q.size() != 0) $display("FAIL rst_mid_strobe got %0d exp 0", got_q.size());
    else passed++;
    send_frame(8'h3C, 1'b1, 1);
    drive(1'b1, 64);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL rst_mid_next got %h exp %h", (got_q.size() > 0) ? got_q[0] : 9'h1ff, exp_q[0]);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_break;
    drive(1'b0, 624);
    exp_q.push_back({1'b1, 8'h00});
    last_dout = 8'h00;
    drive(1'b1, 400);
    send_frame(8'h5A, 1'b1, 1);
    drive(1'b1, 64);
    total++;
    if (got_q.size() != exp_q.size()) $display("FAIL break_count got %0d exp %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL break_word got %h exp %h", (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else passed++;
    end
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_random;
    for (int k = 0; k < 10; k++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) != 0, 1);
      drive(1'b1, $urandom_range(0, 80));
    end
    drive(1'b1, 64);
    total++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL rand_word[%0d] got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else passed++;
    end
    total++;
    if (dout !== last_dout) $display("FAIL rand_hold got %h exp %h", dout, last_dout);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  task automatic test_stop2;
    int base;
    drive(1'b1, 800);
    base = n2;
    send_frame(8'h81, 1'b1, 2);
    drive(1'b1, 100);
    total++;
    if (n2 != base + 1) $display("FAIL stop2_count got %0d exp %0d", n2 - base, 1);
    else passed++;
    total++;
    if ({ferr2, dout2} !== 9'h081 || busy2 !== 1'b0) $display("FAIL stop2_word got %h/%b exp 081/0", {ferr2, dout2}, busy2);
    else passed++;
    total++;
    if (t2 - t1 != 64) $display("FAIL stop2_delay got %0d exp 64", t2 - t1);
    else passed++;
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL stop2_ref got %h exp %h", (got_q.size() > 0) ? got_q[0] : 9'h1ff, exp_q[0]);
    else passed++;
    got_q.delete(); exp_q.delete(); time_q.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_break;
    test_random;
    test_stop2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver.
- Sits directly downstream of the baud tick generator and consumes its one-cycle `baud_rate` pulse on the `s_tick` input.
- Samples the serial line at mid-bit, assembles LSB-first data words, and flags framing errors.
- Presents each received word with a one-cycle done strobe to the downstream FIFO/interface logic.

Parameters:
- DBIT, 8, number of data bits per frame (valid range 5..8).
- SB_TICK, 16, number of s_tick pulses spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clock  input  1  system clock; all flops rise on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, idle high; asynchronous to clock.
- s_tick  input  1  oversample strobe, one clock wide, 16 per bit period; from the baud generator.
- dout  output  DBIT  last received data word, LSB received first.
- rx_done_tick  output  1  one-cycle pulse; dout and frame_err are valid from this cycle on.
- frame_err  output  1  stop-bit sample of the last frame was 0; held until the next frame completes.
- busy  output  1  high while state != IDLE.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous, active-high, named `reset`. While reset is high, all state is cleared immediately.
- Reset values: state=IDLE, tick counter s=0, bit counter n=0, shift register b=0, dout=0, rx_done_tick=0, frame_err=0, busy=0. Both synchronizer flops reset to 1 (line idle).
- Input synchronizer: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s, so there is 2 cycles of input latency.
- s: 4-bit tick counter; it advances only on cycles where s_tick=1. n: 3-bit data-bit counter.
- IDLE: if rx_s==0, go to START with s=0. This check does not wait for a tick.
- START:
  - On s_tick with s==7 (mid start bit): if rx_s==0, go to DATA with s=0, n=0. If rx_s==1, treat it as a false start (glitch) and return to IDLE; no strobe, outputs unchanged.
  - On s_tick with s<7: s<=s+1.
- DATA:
  - On s_tick with s==15: s<=0 and b<={rx_s, b[DBIT-1:1]} (right-shift, LSB first). If n==DBIT-1, go to STOP; otherwise n<=n+1.
  - On s_tick with s<15: s<=s+1.
- STOP:
  - On s_tick with s==SB_TICK-1, go to IDLE. On that same clock edge: rx_done_tick<=1, dout<=b, frame_err<=~rx_s.
  - Otherwise, on s_tick: s<=s+1. For SB_TICK>16, s is widened to 5 bits.
- Output latency: rx_done_tick rises 1 clock after the clock carrying the final stop-bit tick and lasts exactly 1 clock.
- A new frame may start in the cycle right after the return to IDLE. Back-to-back frames with no idle gap must be received without loss.
- A break condition (line held low) produces frame_err=1 and dout=0, then restarts reception after the line returns high and falls again. No lockup.
- s_tick asserted on consecutive clocks is legal; each assertion counts as one tick.
- A reset asserted mid-frame returns the block to IDLE immediately with reset values. The partial frame is discarded and no strobe is produced.
- dout is held between strobes; only a completed frame updates it.

Decomposition:
- Shared include file `uart_defs.vh`:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - OVERSAMPLE=16
  - MID_TICK=7
  - the baud generator's default COUNT, so TX, RX and the baud generator agree.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async reset and a reset-value parameter, reusable by the TX side for CTS.
- FSM and datapath stay in uart_rx.

Test Plan:
- Bench setup: baud generator with COUNT=3, so s_tick is 1 in 4 clocks.
- Frame 0x55, 1 stop -> exactly one rx_done_tick; dout=8'h55, frame_err=0, busy low afterwards.
- Back-to-back frames 0xA3 then 0x0F with zero idle gap -> two strobes 16*10 ticks apart; dout=8'hA3 then 8'h0F, no missed or extra strobe.
- rx low pulse lasting 4 ticks (shorter than mid-start) -> returns to IDLE; no rx_done_tick; dout keeps its previous value.
- Frame 0xC3 with the stop bit driven 0 -> rx_done_tick=1, dout=8'hC3, frame_err=1. A following good frame 0x01 clears frame_err to 0.
- Reset asserted during data bit 4 of 0xFF, released 10 clocks later -> all outputs 0 immediately, busy=0. Next frame 0x3C is received correctly.
- Run with SB_TICK=32 (2 stop bits) and frame 0x81 -> strobe occurs 32 ticks after stop-bit start; dout=8'h81.
